// File: rtl/fib_seq_controller.sv
// Fibonacci term sequencer: streams n_terms terms over valid/ready, stopping early on WIDTH-bit overflow.
// Optional build macro FIB_SEED_EN exposes seed0/seed1; otherwise the seeds are fixed at 0,1.
module fib_seq_controller #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] n_terms,
  input  logic             abort,
  output logic [WIDTH-1:0] term,
  output logic [CNT_W-1:0] term_idx,
  output logic             term_valid,
  input  logic             term_ready,
  output logic             busy,
  output logic             done,
  output logic             ovf
`ifdef FIB_SEED_EN
  ,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a, a_nxt;
  logic [WIDTH-1:0] b, b_nxt;
  logic             b_bad, b_bad_nxt;
  logic [CNT_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] remain, remain_nxt;
  logic             ovf_q, ovf_nxt;
  logic [WIDTH-1:0] seed_a, seed_b;
  logic [WIDTH:0]   sum;
  logic             hs;

`ifdef FIB_SEED_EN
  assign seed_a = seed0;
  assign seed_b = seed1;
`else
  assign seed_a = {WIDTH{1'b0}};
  assign seed_b = WIDTH'(1);
`endif

  assign sum = {1'b0, a} + {1'b0, b};
  assign hs  = term_valid & term_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      b_bad  <= 1'b0;
      idx    <= '0;
      remain <= '0;
      ovf_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      a      <= a_nxt;
      b      <= b_nxt;
      b_bad  <= b_bad_nxt;
      idx    <= idx_nxt;
      remain <= remain_nxt;
      ovf_q  <= ovf_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    a_nxt      = a;
    b_nxt      = b;
    b_bad_nxt  = b_bad;
    idx_nxt    = idx;
    remain_nxt = remain;
    ovf_nxt    = ovf_q;
    term_valid = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          ovf_nxt = 1'b0;
          if (n_terms != '0) begin
            a_nxt      = seed_a;
            b_nxt      = seed_b;
            b_bad_nxt  = 1'b0;
            idx_nxt    = '0;
            remain_nxt = n_terms;
            state_nxt  = RUN;
          end else begin
            state_nxt = FIN;
          end
        end
      end
      RUN: begin
        term_valid = 1'b1;
        busy       = 1'b1;
        // Abort wins over completion; a coincident handshake is still delivered.
        if (abort) begin
          state_nxt = IDLE;
        end else if (hs) begin
          if (remain == CNT_W'(1)) begin
            state_nxt = FIN;
            ovf_nxt   = 1'b0;
          end else if (b_bad) begin
            // Next term would be the truncated sum: stop before emitting it.
            state_nxt = FIN;
            ovf_nxt   = 1'b1;
          end else begin
            a_nxt      = b;
            b_nxt      = sum[WIDTH-1:0];
            b_bad_nxt  = sum[WIDTH];
            idx_nxt    = idx + CNT_W'(1);
            remain_nxt = remain - CNT_W'(1);
          end
        end
      end
      FIN: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign term     = a;
  assign term_idx = idx;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_fib_seq_controller.sv
// Scoreboard bench for fib_seq_controller: stimulus pushes expected terms/done events, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_fib_seq_controller;

  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  typedef struct {
    longint term;
    int     idx;
  } term_exp_t;

  typedef struct {
    bit ovf;
    bit after_hs;
  } done_exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] n_terms;
  logic             abort;
  logic [WIDTH-1:0] term;
  logic [CNT_W-1:0] term_idx;
  logic             term_valid;
  logic             term_ready;
  logic             busy;
  logic             done;
  logic             ovf;
`ifdef FIB_SEED_EN
  logic [WIDTH-1:0] seed0;
  logic [WIDTH-1:0] seed1;
`endif

  fib_seq_controller #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .n_terms(n_terms),
    .abort(abort),
    .term(term),
    .term_idx(term_idx),
    .term_valid(term_valid),
    .term_ready(term_ready),
    .busy(busy),
    .done(done),
    .ovf(ovf)
`ifdef FIB_SEED_EN
    ,
    .seed0(seed0),
    .seed1(seed1)
`endif
  );

  always #5 clk = ~clk;

  term_exp_t exp_q[$];
  done_exp_t done_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;
  int hs_cnt   = 0;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Monitor: handshakes and done pulses are compared against the queues.
  bit             stall_prev = 1'b0;
  bit             hs_prev    = 1'b0;
  logic [WIDTH-1:0] hold_term;
  logic [CNT_W-1:0] hold_idx;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      hs_prev    = 1'b0;
    end else begin
      if (term_valid && stall_prev) begin
        check("stall_term_stable", term, hold_term);
        check("stall_idx_stable", term_idx, hold_idx);
      end
      if (term_valid && term_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_term: got %0d idx %0d, required no term", term, term_idx);
        end else begin
          term_exp_t e;
          e = exp_q.pop_front();
          check("term", term, e.term);
          check("term_idx", term_idx, e.idx);
        end
      end
      if (done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1, required done=0");
        end else begin
          done_exp_t d;
          d = done_q.pop_front();
          check("done_ovf", ovf, d.ovf);
          if (d.after_hs) check("done_follows_last_hs", hs_prev, 1);
        end
      end
      stall_prev = term_valid && !term_ready;
      hs_prev    = term_valid && term_ready;
      hold_term  = term;
      hold_idx   = term_idx;
    end
  end

  task automatic push_term(input longint t, input int i);
    term_exp_t e;
    e.term = t;
    e.idx  = i;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input bit o, input bit after_hs);
    done_exp_t d;
    d.ovf      = o;
    d.after_hs = after_hs;
    done_q.push_back(d);
  endtask

  // Inputs change 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int n);
    start   = 1'b1;
    n_terms = CNT_W'(n);
    step();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int target, input int max_cycles, input string name);
    int c = 0;
    while (done_cnt < target && c < max_cycles) begin
      step();
      c++;
    end
    check({name, "_done_seen"}, done_cnt >= target, 1);
  endtask

  initial begin
    longint fa, fb, ft;
    int     pat[4] = '{1, 0, 0, 1};
    rst        = 1'b1;
    start      = 1'b1;
    n_terms    = 8'd4;
    abort      = 1'b0;
    term_ready = 1'b1;
`ifdef FIB_SEED_EN
    seed0 = 32'd0;
    seed1 = 32'd1;
`endif

    // 1. Reset with start held high
    step();
    step();
    @(negedge clk);
    check("rst_term_valid", term_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_term", term, 0);
    check("rst_term_idx", term_idx, 0);
    @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", term_valid, 0);
    end
    step();

    // 2. Basic run, ready held high
    fa = 0; fb = 1;
    for (int i = 0; i < 10; i++) begin
      push_term(fa, i);
      ft = fa + fb; fa = fb; fb = ft;
    end
    push_done(1'b0, 1'b1);
    pulse_start(10);
    @(negedge clk);
    check("start_latency_valid", term_valid, 1);
    check("start_latency_busy", busy, 1);
    wait_done(1, 30, "basic");
    check("basic_hs_count", hs_cnt, 10);
    step();

    // 3. Backpressure with ready pattern 1,0,0,1
    push_term(0, 0); push_term(1, 1); push_term(1, 2); push_term(2, 3); push_term(3, 4);
    push_done(1'b0, 1'b1);
    pulse_start(5);
    for (int k = 0; k < 40 && done_cnt < 2; k++) begin
      term_ready = pat[k % 4] != 0;
      step();
    end
    wait_done(2, 5, "backpressure");
    check("backpressure_hs_count", hs_cnt, 15);
    term_ready = 1'b1;
    step();

    // 4. Overflow: F(0)..F(47) then stop with ovf
    fa = 0; fb = 1;
    for (int i = 0; i < 48; i++) begin
      push_term(fa, i);
      ft = fa + fb; fa = fb; fb = ft;
    end
    push_done(1'b1, 1'b1);
    pulse_start(60);
    wait_done(3, 80, "overflow");
    check("overflow_hs_count", hs_cnt, 63);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("ovf_sticky", ovf, 1);
      check("ovf_idle_no_valid", term_valid, 0);
    end
    step();

    // 5a. n_terms=0: done one cycle after start, ovf cleared, no term
    push_done(1'b0, 1'b0);
    pulse_start(0);
    @(negedge clk);
    check("zero_done_pulse", done, 1);
    check("zero_no_valid", term_valid, 0);
    check("zero_ovf_cleared", ovf, 0);
    step();
    @(negedge clk);
    check("zero_done_one_cycle", done, 0);
    step();

    // 5b. Abort after third handshake; mid-run start ignored
    push_term(0, 0); push_term(1, 1); push_term(1, 2);
    pulse_start(20);
    start   = 1'b1;
    n_terms = 8'd5;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    @(negedge clk);
    check("abort_valid_low", term_valid, 0);
    check("abort_busy_low", busy, 0);
    check("abort_hs_count", hs_cnt, 66);
    for (int i = 0; i < 5; i++) step();
    check("abort_no_done", done_cnt, 4);

`ifdef FIB_SEED_EN
    // 6. Custom seeds 2,1
    seed0 = 32'd2;
    seed1 = 32'd1;
    push_term(2, 0); push_term(1, 1); push_term(3, 2);
    push_term(4, 3); push_term(7, 4); push_term(11, 5);
    push_done(1'b0, 1'b1);
    pulse_start(6);
    wait_done(5, 20, "seeded");
    step();
`endif

    check("exp_queue_drained", exp_q.size(), 0);
    check("done_queue_drained", done_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout, required completion");
    $fatal(1, "timeout");
  end

endmodule
